// File: rtl/hazard3_trigger_prog_pkg.sv
// Shared definitions for the breakpoint trigger programming sequencer:
// response codes, FSM states, trigger CSR addresses and tdata1 field layout.
package hazard3_trigger_prog_pkg;

    typedef enum logic [1:0] {
        ST_OK          = 2'd0,
        ST_NOTRIG      = 2'd1,
        ST_VERIFY_FAIL = 2'd2
    } status_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SAVE,
        S_SEL,
        S_PROBE,
        S_DISABLE,
        S_WR2,
        S_WR1,
        S_VER1,
        S_VER2,
        S_RESTORE,
        S_RESP
    } state_e;

    localparam logic [11:0] CSR_TSELECT = 12'h7a0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7a1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7a2;
    localparam logic [11:0] CSR_TINFO   = 12'h7a4;

    localparam int TD1_DMODE   = 27;
    localparam int TD1_ACTION  = 12;
    localparam int TD1_M       = 6;
    localparam int TD1_U       = 3;
    localparam int TD1_EXECUTE = 2;

    localparam logic [31:0] TINFO_BREAKPOINT   = 32'h0000_0004;
    localparam logic [31:0] TDATA1_DISABLED    = 32'h2000_0000;
    // Bits that must read back as written: action, m, u, execute
    localparam logic [31:0] TDATA1_VERIFY_MASK = 32'h0000_104c;

endpackage

// File: rtl/hazard3_trigger_prog.sv
// Sequencer that programs one breakpoint trigger over the CSR config port,
// preserving tselect. Optional readback check: HAZARD3_TRIGGER_PROG_VERIFY_EN.
module hazard3_trigger_prog
    import hazard3_trigger_prog_pkg::*;
#(
    parameter int BREAKPOINT_TRIGGERS = 4,
    parameter int W_DATA              = 32,
    parameter int W_ADDR              = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_index,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic              req_enable,
    input  logic              req_action,
    input  logic              req_m,
    input  logic              req_u,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic              cfg_req,
    input  logic              cfg_gnt,
    output logic [11:0]       cfg_addr,
    output logic              cfg_wen,
    output logic [W_DATA-1:0] cfg_wdata,
    input  logic [W_DATA-1:0] cfg_rdata
);

    localparam logic [W_DATA-1:0] TINFO_BP_W = W_DATA'(TINFO_BREAKPOINT);

    function automatic logic [31:0] pack_tdata1(input logic action, input logic m,
                                                input logic u, input logic execute);
        logic [31:0] v;
        v              = TDATA1_DISABLED;
        v[TD1_DMODE]   = action;
        v[TD1_ACTION]  = action;
        v[TD1_M]       = m;
        v[TD1_U]       = u;
        v[TD1_EXECUTE] = execute;
        return v;
    endfunction

    state_e              state_q, state_d;
    status_e             status_q, status_d;
    logic [3:0]          idx_q;
    logic [W_ADDR-1:0]   addr_q;
    logic                enable_q, action_q, m_q, u_q;
    logic [W_DATA-1:0]   saved_q;
    logic                wr;
    logic [31:0]         tdata1_val;
    logic                in_range;

    assign tdata1_val = pack_tdata1(action_q, m_q, u_q, enable_q);
    assign in_range   = 32'(req_index) < 32'(BREAKPOINT_TRIGGERS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // Request fields and the saved tselect are pure data: no reset needed
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req_valid) begin
            idx_q    <= req_index;
            addr_q   <= req_addr;
            enable_q <= req_enable;
            action_q <= req_action;
            m_q      <= req_m;
            u_q      <= req_u;
        end
        if (state_q == S_SAVE && cfg_gnt) begin
            saved_q <= cfg_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        cfg_req   = 1'b0;
        wr        = 1'b0;
        cfg_addr  = 12'h000;
        cfg_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    status_d = in_range ? ST_OK : ST_NOTRIG;
                    state_d  = in_range ? S_SAVE : S_RESP;
                end
            end
            S_SAVE: begin
                cfg_req  = 1'b1;
                cfg_addr = CSR_TSELECT;
                if (cfg_gnt) state_d = S_SEL;
            end
            S_SEL: begin
                cfg_req   = 1'b1;
                wr        = 1'b1;
                cfg_addr  = CSR_TSELECT;
                cfg_wdata = W_DATA'(idx_q);
                if (cfg_gnt) state_d = S_PROBE;
            end
            S_PROBE: begin
                cfg_req  = 1'b1;
                cfg_addr = CSR_TINFO;
                if (cfg_gnt) begin
                    if (cfg_rdata != TINFO_BP_W) begin
                        status_d = ST_NOTRIG;
                        state_d  = S_RESTORE;
                    end else begin
                        state_d  = S_DISABLE;
                    end
                end
            end
            S_DISABLE: begin
                cfg_req   = 1'b1;
                wr        = 1'b1;
                cfg_addr  = CSR_TDATA1;
                cfg_wdata = W_DATA'(TDATA1_DISABLED);
                if (cfg_gnt) state_d = S_WR2;
            end
            S_WR2: begin
                cfg_req   = 1'b1;
                wr        = 1'b1;
                cfg_addr  = CSR_TDATA2;
                cfg_wdata = W_DATA'(addr_q);
                if (cfg_gnt) state_d = S_WR1;
            end
            S_WR1: begin
                cfg_req   = 1'b1;
                wr        = 1'b1;
                cfg_addr  = CSR_TDATA1;
                cfg_wdata = W_DATA'(tdata1_val);
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
                if (cfg_gnt) state_d = S_VER1;
`else
                if (cfg_gnt) state_d = S_RESTORE;
`endif
            end
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
            S_VER1: begin
                cfg_req  = 1'b1;
                cfg_addr = CSR_TDATA1;
                if (cfg_gnt) begin
                    if (((cfg_rdata[31:0] ^ tdata1_val) & TDATA1_VERIFY_MASK) != 32'h0)
                        status_d = ST_VERIFY_FAIL;
                    state_d = S_VER2;
                end
            end
            S_VER2: begin
                cfg_req  = 1'b1;
                cfg_addr = CSR_TDATA2;
                if (cfg_gnt) begin
                    if (cfg_rdata != W_DATA'(addr_q))
                        status_d = ST_VERIFY_FAIL;
                    state_d = S_RESTORE;
                end
            end
`endif
            S_RESTORE: begin
                cfg_req   = 1'b1;
                wr        = 1'b1;
                cfg_addr  = CSR_TSELECT;
                cfg_wdata = saved_q;
                if (cfg_gnt) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_wen    = wr & cfg_gnt;
    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = status_q;

endmodule
